// File: rtl/input_sram_arbiter.sv
// Arbitrates one DMA write requester and NUM_RD PE read requesters onto a single Input SRAM controller.
// Optional INPUT_ARB_ADDR_CHECK_EN rejects winners addressing a nonexistent bank or out-of-range word.
module input_sram_arbiter #(
  parameter int NUM_RD     = 4,
  parameter int MAX_WR_RUN = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_req,
  input  logic [31:0]         wr_addr,
  input  logic [63:0]         wr_data,
  output logic                wr_grant,
  output logic                wr_done,
  input  logic [NUM_RD-1:0]   rd_req,
  input  logic [NUM_RD*32-1:0] rd_addr,
  output logic [NUM_RD-1:0]   rd_grant,
  output logic [NUM_RD-1:0]   rd_valid,
  output logic [63:0]         rd_data,
  output logic                err,
  output logic                sram_w_en,
  output logic                sram_r_en,
  output logic [31:0]         sram_w_addr,
  output logic [63:0]         sram_w_d,
  output logic [31:0]         sram_r_addr,
  input  logic [63:0]         sram_r_d,
  input  logic                sram_d_ready,
  input  logic                sram_w_done,
  output logic [1:0]          fsm_state
);

  localparam int IW  = $clog2(NUM_RD);
  localparam int WRW = $clog2(MAX_WR_RUN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t          state;
  logic            op_rd;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rd_ptr;
  logic [WRW-1:0]  wr_run;
  logic [3:0]      wdog;

  logic            found;
  logic [IW:0]     sum;
  logic [IW-1:0]   rd_win;
  logic [31:0]     addr_arr [NUM_RD];
  logic [31:0]     win_rd_addr;
  logic            pick_wr;
  logic            pick_rd;
  logic            reject;

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) addr_arr[i] = rd_addr[32*i +: 32];
  end

  // Round-robin search starting at rd_ptr, wrapping modulo NUM_RD.
  always_comb begin
    found  = 1'b0;
    rd_win = '0;
    sum    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      sum = {1'b0, rd_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_RD)) sum = sum - (IW+1)'(NUM_RD);
      if (!found && rd_req[sum[IW-1:0]]) begin
        found  = 1'b1;
        rd_win = sum[IW-1:0];
      end
    end
  end

  assign win_rd_addr = addr_arr[rd_win];
  assign pick_wr     = wr_req && !((wr_run == WRW'(MAX_WR_RUN)) && (|rd_req));
  assign pick_rd     = !pick_wr && (|rd_req);

`ifdef INPUT_ARB_ADDR_CHECK_EN
  logic [31:0] win_addr;
  assign win_addr = pick_wr ? wr_addr : win_rd_addr;
  assign reject   = (win_addr[13:11] > 3'd5) || (win_addr[31:14] != 18'd0);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op_rd       <= 1'b0;
      owner       <= '0;
      rd_ptr      <= '0;
      wr_run      <= '0;
      wdog        <= '0;
      wr_grant    <= 1'b0;
      rd_grant    <= '0;
      err         <= 1'b0;
      sram_w_en   <= 1'b0;
      sram_r_en   <= 1'b0;
      sram_w_addr <= '0;
      sram_w_d    <= '0;
      sram_r_addr <= '0;
    end else begin
      wr_grant  <= 1'b0;
      rd_grant  <= '0;
      err       <= 1'b0;
      sram_w_en <= 1'b0;
      sram_r_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_wr || pick_rd) begin
            if (pick_wr) begin
              wr_grant <= 1'b1;
              if (wr_run != WRW'(MAX_WR_RUN)) wr_run <= wr_run + 1'b1;
            end else begin
              rd_grant <= NUM_RD'(1) << rd_win;
              rd_ptr   <= (rd_win == IW'(NUM_RD - 1)) ? '0 : rd_win + 1'b1;
              wr_run   <= '0;
            end
            op_rd <= pick_rd;
            owner <= rd_win;
            // A rejected winner is acknowledged but never reaches the SRAM.
            if (reject) begin
              err <= 1'b1;
            end else begin
              state <= ISSUE;
              if (pick_wr) begin
                sram_w_en   <= 1'b1;
                sram_w_addr <= wr_addr;
                sram_w_d    <= wr_data;
              end else begin
                sram_r_en   <= 1'b1;
                sram_r_addr <= win_rd_addr;
              end
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          wdog  <= '0;
        end
        WAIT: begin
          if (op_rd ? sram_d_ready : sram_w_done) begin
            state <= IDLE;
          end else if (wdog == 4'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_done   = sram_w_done && (state == WAIT) && !op_rd;
  assign rd_data   = sram_r_d;
  assign fsm_state = state;

  always_comb begin
    rd_valid = '0;
    if (sram_d_ready && (state == WAIT) && op_rd) rd_valid[owner] = 1'b1;
  end

endmodule

// File: tb/tb_input_sram_arbiter.sv
// Directed bench for input_sram_arbiter: an SRAM controller model plus a grant/completion/err scoreboard.
// Handshake: a requester holds req until it sees its grant pulse, then drops req before the next edge.
module tb_input_sram_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [63:0]  wr_data;
  logic         wr_grant;
  logic         wr_done;
  logic [3:0]   rd_req;
  logic [127:0] rd_addr;
  logic [3:0]   rd_grant;
  logic [3:0]   rd_valid;
  logic [63:0]  rd_data;
  logic         err;
  logic         sram_w_en;
  logic         sram_r_en;
  logic [31:0]  sram_w_addr;
  logic [63:0]  sram_w_d;
  logic [31:0]  sram_r_addr;
  logic [63:0]  sram_r_d = '0;
  logic         sram_d_ready = 1'b0;
  logic         sram_w_done = 1'b0;
  logic [1:0]   fsm_state;

  input_sram_arbiter dut (
    .clock(clock), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid),
    .rd_data(rd_data), .err(err),
    .sram_w_en(sram_w_en), .sram_r_en(sram_r_en),
    .sram_w_addr(sram_w_addr), .sram_w_d(sram_w_d), .sram_r_addr(sram_r_addr),
    .sram_r_d(sram_r_d), .sram_d_ready(sram_d_ready), .sram_w_done(sram_w_done),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- SRAM controller model ----------------
  // Responds one cycle after the enable; a read returns {addr, ~addr}.
  logic hang    = 1'b0;
  logic stray_r = 1'b0;
  logic stray_w = 1'b0;

  always @(posedge clock) begin
    sram_w_done  <= (sram_w_en && !hang) || stray_w;
    sram_d_ready <= (sram_r_en && !hang) || stray_r;
    if (sram_r_en) sram_r_d <= {sram_r_addr, ~sram_r_addr};
  end

  // ---------------- scoreboard ----------------
  logic [100:0] grant_q [$];   // {is_rd, idx[2:0], en, addr[31:0], wdata[63:0]}
  logic [67:0]  cpl_q   [$];   // {is_rd, idx[2:0], rdata[63:0]}
  logic [0:0]   err_q   [$];   // 0: err with grant, 1: watchdog
  int errors = 0;
  int checks = 0;
  int last_gcyc = 0;
  logic [100:0] obs_g;
  logic [67:0]  obs_c;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] enc(input logic [3:0] v);
    enc = 3'd0;
    for (int k = 0; k < 4; k++) if (v[k]) enc = 3'(k);
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_grant || (rd_grant != 4'd0)) begin
        chk("grant_onehot", 128'($countones({wr_grant, rd_grant})), 128'd1);
        if (wr_grant)
          obs_g = {1'b0, 3'd0, sram_w_en, sram_w_en ? sram_w_addr : 32'h0, sram_w_en ? sram_w_d : 64'h0};
        else
          obs_g = {1'b1, enc(rd_grant), sram_r_en, sram_r_en ? sram_r_addr : 32'h0, 64'h0};
        if (grant_q.size() == 0) chk("unexpected_grant", obs_g, 128'd0);
        else chk("grant", obs_g, grant_q.pop_front());
        last_gcyc = cyc;
      end
      if (wr_done || (rd_valid != 4'd0)) begin
        obs_c = wr_done ? {1'b0, 3'd0, 64'h0} : {1'b1, enc(rd_valid), rd_data};
        if (cpl_q.size() == 0) chk("unexpected_completion", obs_c, 128'd0);
        else chk("completion", obs_c, cpl_q.pop_front());
        chk("completion_latency", 128'(cyc - last_gcyc), 128'd1);
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err", 128'd1, 128'd0);
        else if (err_q.pop_front() == 1'b0) chk("reject_err_latency", 128'(cyc - last_gcyc), 128'd0);
        else chk("timeout_err_latency", 128'((cyc - last_gcyc == 15) || (cyc - last_gcyc == 16)), 128'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input bit en, input bit done);
    grant_q.push_back({1'b0, 3'd0, en, en ? a : 32'h0, en ? d : 64'h0});
    if (done) cpl_q.push_back({1'b0, 3'd0, 64'h0});
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    for (int n = 0; n < 40 && !wr_grant; n++) @(negedge clock);
    chk("wr_grant_seen", 128'(wr_grant), 128'd1);
    wr_req = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [31:0] a, input logic [63:0] word,
                         input bit en, input bit valid);
    grant_q.push_back({1'b1, 3'(i), en, en ? a : 32'h0, 64'h0});
    if (valid) cpl_q.push_back({1'b1, 3'(i), word});
    rd_addr[32*i +: 32] = a;
    rd_req[i] = 1'b1;
    for (int n = 0; n < 40 && !rd_grant[i]; n++) @(negedge clock);
    chk("rd_grant_seen", 128'(rd_grant[i]), 128'd1);
    rd_req[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rtab [4];
  logic [63:0] wtab [4];
  int g;
  int prev;

  initial begin
    rtab[0] = 32'h0000_0100; wtab[0] = 64'h0000_0100_FFFF_FEFF;
    rtab[1] = 32'h0000_0901; wtab[1] = 64'h0000_0901_FFFF_F6FE;
    rtab[2] = 32'h0000_1102; wtab[2] = 64'h0000_1102_FFFF_EEFD;
    rtab[3] = 32'h0000_2803; wtab[3] = 64'h0000_2803_FFFF_D7FC;

    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
    wait_cycles(3);
    reset = 1'b0;

    // Idle after reset, with stray completion strobes that must be ignored.
    for (int i = 0; i < 10; i++) begin
      stray_r = i[0];
      stray_w = i[1];
      @(negedge clock);
      chk("idle_outputs",
          {wr_grant, wr_done, rd_grant, rd_valid, err, sram_w_en, sram_r_en,
           sram_w_addr, sram_r_addr, |sram_w_d, fsm_state}, 128'd0);
    end
    stray_r = 1'b0; stray_w = 1'b0;
    wait_cycles(3);

    // Single write.
    do_write(32'h0000_0805, 64'h0000_DEAD_BEEF_0123, 1'b1, 1'b1);
    wait_cycles(4);

    // Round-robin with all readers held: 0,1,2,3,0 every 3 cycles.
    for (int i = 0; i < 4; i++) rd_addr[32*i +: 32] = rtab[i];
    for (int k = 0; k < 5; k++) begin
      grant_q.push_back({1'b1, 3'(k % 4), 1'b1, rtab[k % 4], 64'h0});
      cpl_q.push_back({1'b1, 3'(k % 4), wtab[k % 4]});
    end
    rd_req = 4'b1111;
    g = 0; prev = 0;
    for (int n = 0; n < 100 && g < 5; n++) begin
      @(negedge clock);
      if (rd_grant != 4'd0) begin
        g++;
        if (g > 1) chk("rr_spacing", 128'(cyc - prev), 128'd3);
        prev = cyc;
        if (g == 5) rd_req = 4'b0000;
      end
    end
    chk("rr_grants_seen", 128'(g), 128'd5);
    wait_cycles(4);

    // Starvation guard: 4 writes, forced read 2, writes resume.
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        grant_q.push_back({1'b1, 3'd2, 1'b1, rtab[2], 64'h0});
        cpl_q.push_back({1'b1, 3'd2, wtab[2]});
      end else begin
        grant_q.push_back({1'b0, 3'd0, 1'b1, 32'h0000_1000, 64'h1111_2222_3333_4444});
        cpl_q.push_back({1'b0, 3'd0, 64'h0});
      end
    end
    wr_addr = 32'h0000_1000; wr_data = 64'h1111_2222_3333_4444;
    wr_req = 1'b1; rd_req = 4'b0100;
    g = 0;
    for (int n = 0; n < 100 && g < 6; n++) begin
      @(negedge clock);
      if (wr_grant || (rd_grant != 4'd0)) g++;
      if (rd_grant[2]) rd_req[2] = 1'b0;
      if (g == 6) wr_req = 1'b0;
    end
    chk("starve_grants_seen", 128'(g), 128'd6);
    wait_cycles(4);

    // Watchdog: controller never answers; the next request is served normally.
    hang = 1'b1;
    err_q.push_back(1'b1);
    do_read(3, rtab[3], wtab[3], 1'b1, 1'b0);
    wait_cycles(20);
    hang = 1'b0;
    do_write(32'h0000_0006, 64'h0000_0000_0000_0055, 1'b1, 1'b1);
    wait_cycles(4);

    // Reset in the middle of a write: no done afterwards, stray strobes ignored.
    hang = 1'b1;
    do_write(32'h0000_0810, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0);
    wait_cycles(2);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_midop_state", {fsm_state, sram_w_en, wr_done}, 128'd0);
    reset = 1'b0; hang = 1'b0; stray_w = 1'b1; stray_r = 1'b1;
    @(negedge clock);
    stray_w = 1'b0; stray_r = 1'b0;
    wait_cycles(3);
    do_read(1, rtab[1], wtab[1], 1'b1, 1'b1);
    wait_cycles(4);

`ifdef INPUT_ARB_ADDR_CHECK_EN
    // Nonexistent bank and out-of-range word are rejected with grant + err.
    err_q.push_back(1'b0);
    do_read(0, 32'h0000_3000, 64'h0, 1'b0, 1'b0);
    wait_cycles(4);
    err_q.push_back(1'b0);
    do_write(32'h0000_4000, 64'h1, 1'b0, 1'b0);
    wait_cycles(4);
`endif

    wait_cycles(5);
    chk("grant_q_drained", 128'(grant_q.size()), 128'd0);
    chk("cpl_q_drained", 128'(cpl_q.size()), 128'd0);
    chk("err_q_drained", 128'(err_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
